// File: rtl/data_mem_access_unit.sv
// ----------------------------------------------------------------------------
// data_mem_access_unit
//
// Memory-access stage that sits directly in front of the load extractor.
// It takes one load or store from the pipeline and checks that it is legal.
// It then runs a valid/ready request to the data memory, with a word-aligned
// address, byte enables and lane-replicated store data. For a load it waits
// for the read word and captures it.
//
// The captured word (RDRaw), the byte offset (ByteOff) and the funct3 type
// (LoadType) feed the load extractor. They hold their values until the next
// legal load is accepted. The pipeline is stalled while an access is in
// flight.
//
// Ports
//   clk, rst       clock (rising edge) / asynchronous active-high reset
//   ReqValid       pipeline presents an access
//   ReqReady       unit can accept (IDLE only)
//   MemWrite       1 = store, 0 = load
//   Addr           byte address
//   Type           funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   WD             right-aligned store data
//   MemReqValid    request to data memory
//   MemReqReady    memory accepts request
//   MemAddr        word-aligned address
//   MemWE          write strobe
//   MemBE          byte enables
//   MemWD          lane-replicated store data
//   MemRspValid    read data valid (only looked at while waiting)
//   MemRData       read word
//   RDRaw          captured read word
//   ByteOff        captured Addr[1:0] of the last load
//   LoadType       captured Type of the last load
//   RspValid       one-cycle completion pulse
//   Stall          pipeline hold
//   Fault          one-cycle pulse on a misaligned/illegal access
//   Timeout        one-cycle pulse when memory never answered a load
// ----------------------------------------------------------------------------
module data_mem_access_unit #(
    parameter int MEM_LAT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [2:0]  Type,
    input  logic [31:0] WD,
    output logic        MemReqValid,
    input  logic        MemReqReady,
    output logic [31:0] MemAddr,
    output logic        MemWE,
    output logic [3:0]  MemBE,
    output logic [31:0] MemWD,
    input  logic        MemRspValid,
    input  logic [31:0] MemRData,
    output logic [31:0] RDRaw,
    output logic [1:0]  ByteOff,
    output logic [2:0]  LoadType,
    output logic        RspValid,
    output logic        Stall,
    output logic        Fault,
    output logic        Timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // The wait counter runs 0 .. MEM_LAT_MAX-1. Timeout is registered on the
    // last count, so it becomes visible MEM_LAT_MAX cycles after WAIT is
    // entered.
    localparam logic [7:0] CNT_LAST = 8'(MEM_LAT_MAX - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       legal;

    // Access size comes from Type[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] off);
        case (size)
            2'b00:   byte_enable = 4'b0001 << off;
            2'b01:   byte_enable = 4'b0011 << {off[1], 1'b0};
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                              input logic [31:0] data);
        case (size)
            2'b00:   lane_data = {4{data[7:0]}};
            2'b01:   lane_data = {2{data[15:0]}};
            default: lane_data = data;
        endcase
    endfunction

    always_comb begin
        legal = 1'b1;
        if (Type == 3'b011 || Type == 3'b110 || Type == 3'b111)
            legal = 1'b0;
        if (MemWrite && Type[2])
            legal = 1'b0;
        if (Type[1:0] == 2'b01 && Addr[0])
            legal = 1'b0;
        if (Type[1:0] == 2'b10 && Addr[1:0] != 2'b00)
            legal = 1'b0;
    end

    assign ReqReady = (state == IDLE);
    assign Stall    = (state == IDLE && ReqValid && legal) ||
                      (state == ISSUE) || (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            MemReqValid <= 1'b0;
            MemWE       <= 1'b0;
            MemBE       <= '0;
            MemAddr     <= '0;
            MemWD       <= '0;
            RDRaw       <= '0;
            ByteOff     <= '0;
            LoadType    <= '0;
            RspValid    <= 1'b0;
            Fault       <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            // Single-cycle pulses are cleared by default.
            RspValid <= 1'b0;
            Fault    <= 1'b0;
            Timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        if (legal) begin
                            MemAddr     <= {Addr[31:2], 2'b00};
                            MemWE       <= MemWrite;
                            MemBE       <= byte_enable(Type[1:0], Addr[1:0]);
                            MemWD       <= lane_data(Type[1:0], WD);
                            MemReqValid <= 1'b1;
                            if (!MemWrite) begin
                                ByteOff  <= Addr[1:0];
                                LoadType <= Type;
                            end
                            state <= ISSUE;
                        end else begin
                            Fault <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // All Mem* fields stay untouched until the handshake.
                    if (MemReqReady) begin
                        MemReqValid <= 1'b0;
                        wait_cnt    <= '0;
                        if (MemWE) begin
                            RspValid <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (MemRspValid) begin
                        RDRaw    <= MemRData;
                        RspValid <= 1'b1;
                        state    <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        Timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid, ReqReady, MemWrite;
    logic [31:0] Addr, WD;
    logic [2:0]  Type;
    logic        MemReqValid, MemReqReady, MemWE;
    logic [31:0] MemAddr, MemWD, MemRData, RDRaw;
    logic [3:0]  MemBE;
    logic        MemRspValid;
    logic [1:0]  ByteOff;
    logic [2:0]  LoadType;
    logic        RspValid, Stall, Fault, Timeout;

    data_mem_access_unit #(.MEM_LAT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .MemWrite(MemWrite),
        .Addr(Addr), .Type(Type), .WD(WD),
        .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
        .MemAddr(MemAddr), .MemWE(MemWE), .MemBE(MemBE), .MemWD(MemWD),
        .MemRspValid(MemRspValid), .MemRData(MemRData),
        .RDRaw(RDRaw), .ByteOff(ByteOff), .LoadType(LoadType),
        .RspValid(RspValid), .Stall(Stall), .Fault(Fault), .Timeout(Timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic [1:0]  off;
        logic [2:0]  lt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference for what the extractor-facing registers should hold.
    logic [31:0] last_rd  = 32'h0;
    logic [1:0]  last_off = 2'h0;
    logic [2:0]  last_lt  = 3'h0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ReqValid = 0; MemWrite = 0; Addr = 0; Type = 0; WD = 0;
        MemReqReady = 0; MemRspValid = 0; MemRData = 0;
        #12;
        n_checks++;
        if ({MemReqValid, MemWE, MemBE, MemAddr, MemWD, RDRaw, ByteOff, LoadType,
             RspValid, Fault, Timeout, Stall} !== '0 || ReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: MemReqValid=%b MemAddr=%h MemBE=%b RDRaw=%h ReqReady=%b (required all 0, ReqReady 1)",
                     MemReqValid, MemAddr, MemBE, RDRaw, ReqReady);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load(input logic [31:0] a, input logic [31:0] data,
                             input logic [2:0] t, input logic [3:0] be);
        next_cycle();
        ReqValid = 1; MemWrite = 0; Addr = a; Type = t; WD = 32'hFFFF_FFFF;
        MemReqReady = 1;
        last_rd = data; last_off = a[1:0]; last_lt = t;
        exp_q.push_back({data, a[1:0], t});
        @(negedge clk);
        n_checks++;
        if (Stall !== 1'b1) begin
            n_fail++; $display("FAIL load_accept_stall: Stall=%b required 1", Stall);
        end
        next_cycle();                    // c1: ISSUE
        ReqValid = 0;
        @(negedge clk);
        n_checks++;
        if (MemReqValid !== 1'b1 || MemAddr !== {a[31:2], 2'b00} || MemBE !== be ||
            MemWE !== 1'b0 || ReqReady !== 1'b0) begin
            n_fail++;
            $display("FAIL load_issue: MemReqValid=%b MemAddr=%h MemBE=%b MemWE=%b ReqReady=%b required 1 %h %b 0 0",
                     MemReqValid, MemAddr, MemBE, MemWE, ReqReady, {a[31:2], 2'b00}, be);
        end
        next_cycle();                    // c2: WAIT, response arrives
        MemReqReady = 0; MemRspValid = 1; MemRData = data;
        @(negedge clk);
        n_checks++;
        if (MemReqValid !== 1'b0 || RspValid !== 1'b0 || Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_wait: MemReqValid=%b RspValid=%b Stall=%b required 0 0 1",
                     MemReqValid, RspValid, Stall);
        end
        next_cycle();                    // c3: DONE
        MemRspValid = 0; MemRData = 0;
        @(negedge clk);
        n_checks++;
        if (RspValid !== 1'b1 || Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: RspValid=%b Stall=%b required 1 0", RspValid, Stall);
        end else if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL load_scoreboard: response with empty queue");
        end else begin
            cur = exp_q.pop_front();
            if (RDRaw !== cur.rd || ByteOff !== cur.off || LoadType !== cur.lt) begin
                n_fail++;
                $display("FAIL load_data: RDRaw=%h ByteOff=%0d LoadType=%b required %h %0d %b",
                         RDRaw, ByteOff, LoadType, cur.rd, cur.off, cur.lt);
            end
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL load_idle: RspValid=%b ReqReady=%b required 0 1", RspValid, ReqReady);
        end
    endtask

    task automatic test_store_byte();
        next_cycle();
        ReqValid = 1; MemWrite = 1; Addr = 32'h203; Type = 3'b000; WD = 32'h0000_00A5;
        MemReqReady = 1;
        exp_q.push_back({last_rd, last_off, last_lt});
        next_cycle();                    // c1: ISSUE
        ReqValid = 0;
        @(negedge clk);
        n_checks++;
        if (MemReqValid !== 1'b1 || MemAddr !== 32'h200 || MemBE !== 4'b1000 ||
            MemWD !== 32'hA5A5_A5A5 || MemWE !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_issue: MemReqValid=%b MemAddr=%h MemBE=%b MemWD=%h MemWE=%b required 1 00000200 1000 a5a5a5a5 1",
                     MemReqValid, MemAddr, MemBE, MemWD, MemWE);
        end
        next_cycle();                    // c2: DONE
        MemReqReady = 0;
        @(negedge clk);
        n_checks++;
        if (RspValid !== 1'b1 || MemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_done: RspValid=%b MemReqValid=%b required 1 0", RspValid, MemReqValid);
        end else if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL sb_scoreboard: response with empty queue");
        end else begin
            cur = exp_q.pop_front();
            if (RDRaw !== cur.rd || ByteOff !== cur.off || LoadType !== cur.lt) begin
                n_fail++;
                $display("FAIL sb_load_regs: RDRaw=%h ByteOff=%0d LoadType=%b required %h %0d %b",
                         RDRaw, ByteOff, LoadType, cur.rd, cur.off, cur.lt);
            end
        end
    endtask

    task automatic test_store_half_backpressure();
        next_cycle();
        ReqValid = 1; MemWrite = 1; Addr = 32'h102; Type = 3'b001; WD = 32'h0000_1234;
        MemReqReady = 0;
        exp_q.push_back({last_rd, last_off, last_lt});
        for (int i = 0; i < 4; i++) begin   // c1..c3 stalled, c4 handshake
            next_cycle();
            ReqValid = 0;
            MemReqReady = (i == 3);
            @(negedge clk);
            n_checks++;
            if (MemReqValid !== 1'b1 || MemAddr !== 32'h100 || MemBE !== 4'b1100 ||
                MemWD !== 32'h1234_1234 || MemWE !== 1'b1 || Stall !== 1'b1 || RspValid !== 1'b0) begin
                n_fail++;
                $display("FAIL sh_hold[%0d]: MemReqValid=%b MemAddr=%h MemBE=%b MemWD=%h Stall=%b RspValid=%b required 1 00000100 1100 12341234 1 0",
                         i, MemReqValid, MemAddr, MemBE, MemWD, Stall, RspValid);
            end
        end
        next_cycle();
        MemReqReady = 0;
        @(negedge clk);
        n_checks++;
        if (RspValid !== 1'b1 || MemReqValid !== 1'b0 || Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_done: RspValid=%b MemReqValid=%b Stall=%b required 1 0 0",
                     RspValid, MemReqValid, Stall);
        end else if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL sh_scoreboard: response with empty queue");
        end else begin
            cur = exp_q.pop_front();
            if (RDRaw !== cur.rd) begin
                n_fail++; $display("FAIL sh_rdraw: RDRaw=%h required %h", RDRaw, cur.rd);
            end
        end
    endtask

    task automatic test_fault();
        logic [31:0] fa [3] = '{32'h101, 32'h100, 32'h100};
        logic [2:0]  ft [3] = '{3'b001, 3'b011, 3'b100};
        logic        fw [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ReqValid = 1; MemWrite = fw[i]; Addr = fa[i]; Type = ft[i]; WD = 32'h5555_5555;
            MemReqReady = 1;
            @(negedge clk);
            n_checks++;
            if (Stall !== 1'b0 || ReqReady !== 1'b1) begin
                n_fail++;
                $display("FAIL fault_accept[%0d]: Stall=%b ReqReady=%b required 0 1", i, Stall, ReqReady);
            end
            next_cycle();
            ReqValid = 0;
            @(negedge clk);
            n_checks++;
            if (Fault !== 1'b1 || MemReqValid !== 1'b0 || ReqReady !== 1'b1 || RspValid !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_pulse[%0d]: Fault=%b MemReqValid=%b ReqReady=%b RspValid=%b required 1 0 1 0",
                         i, Fault, MemReqValid, ReqReady, RspValid);
            end
            next_cycle();
            @(negedge clk);
            n_checks++;
            if (Fault !== 1'b0 || MemReqValid !== 1'b0 || RspValid !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_clear[%0d]: Fault=%b MemReqValid=%b RspValid=%b required 0 0 0",
                         i, Fault, MemReqValid, RspValid);
            end
        end
        MemReqReady = 0;
    endtask

    task automatic test_timeout();
        next_cycle();
        ReqValid = 1; MemWrite = 0; Addr = 32'h3; Type = 3'b100; MemReqReady = 1;
        last_off = 2'd3; last_lt = 3'b100;   // RDRaw keeps its old value
        next_cycle();                    // c1: ISSUE
        ReqValid = 0;
        next_cycle();                    // c2: first WAIT cycle
        MemReqReady = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (Timeout !== 1'b0 || Stall !== 1'b1 || ReqReady !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: Timeout=%b Stall=%b ReqReady=%b required 0 1 0",
                         i, Timeout, Stall, ReqReady);
            end
            next_cycle();
        end
        @(negedge clk);                  // 4 cycles after entering WAIT
        n_checks++;
        if (Timeout !== 1'b1 || RspValid !== 1'b0 || ReqReady !== 1'b1 || RDRaw !== last_rd ||
            ByteOff !== last_off || LoadType !== last_lt) begin
            n_fail++;
            $display("FAIL timeout_pulse: Timeout=%b RspValid=%b ReqReady=%b RDRaw=%h ByteOff=%0d LoadType=%b required 1 0 1 %h %0d %b",
                     Timeout, RspValid, ReqReady, RDRaw, ByteOff, LoadType, last_rd, last_off, last_lt);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (Timeout !== 1'b0 || RspValid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: Timeout=%b RspValid=%b required 0 0", Timeout, RspValid);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        ReqValid = 1; MemWrite = 0; Addr = 32'h108; Type = 3'b010; MemReqReady = 1;
        next_cycle();                    // ISSUE
        ReqValid = 0;
        next_cycle();                    // WAIT
        MemReqReady = 0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({MemReqValid, MemWE, MemBE, MemAddr, MemWD, RDRaw, ByteOff, LoadType,
             RspValid, Fault, Timeout, Stall} !== '0 || ReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: MemReqValid=%b MemAddr=%h RDRaw=%h LoadType=%b Stall=%b ReqReady=%b required all 0, ReqReady 1",
                     MemReqValid, MemAddr, RDRaw, LoadType, Stall, ReqReady);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        MemRspValid = 1; MemRData = 32'h1111_1111;
        next_cycle();
        MemRspValid = 0; MemRData = 0;
        @(negedge clk);
        n_checks++;
        if (RspValid !== 1'b0 || RDRaw !== 32'h0 || MemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_late_rsp: RspValid=%b RDRaw=%h MemReqValid=%b required 0 00000000 0",
                     RspValid, RDRaw, MemReqValid);
        end
    endtask

    initial begin
        test_reset();
        test_load(32'h100, 32'hDEAD_BEEF, 3'b010, 4'b1111);
        test_store_byte();
        test_store_half_backpressure();
        test_fault();
        test_timeout();
        test_load(32'h104, 32'h0BAD_F00D, 3'b010, 4'b1111);
        test_load(32'h2, 32'hCAFE_0001, 3'b101, 4'b1100);
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
